// File: rtl/jk_ctrl_pkg.sv
// Shared types for the JK command controller: command encoding and debounce FSM states.
package jk_ctrl_pkg;

    typedef enum logic [1:0] {CMD_NONE, CMD_SET, CMD_CLR, CMD_TOG} jk_cmd_t;

    typedef enum logic [1:0] {RELEASED, PRESS_CHK, HELD, RELEASE_CHK} db_state_t;

    // Returns {j, k} for a command.
    function automatic logic [1:0] to_jk(input jk_cmd_t cmd);
        logic [1:0] jk;
        case (cmd)
            CMD_SET: jk = 2'b10;
            CMD_CLR: jk = 2'b01;
            CMD_TOG: jk = 2'b11;
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, debounce FSM with stability counter,
// and a single-cycle registered press event on an accepted press.
module btn_debounce
    import jk_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press_evt
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

    logic [1:0]       sync_q;
    logic             s;
    db_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_evt_q;

    assign s         = sync_q[1];
    assign press_evt = press_evt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q      <= '0;
            state_q     <= RELEASED;
            cnt_q       <= '0;
            press_evt_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], btn_raw};
            press_evt_q <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (s) begin
                        state_q <= PRESS_CHK;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                PRESS_CHK: begin
                    if (!s) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(DB_CYCLES)) begin
                        state_q     <= HELD;
                        cnt_q       <= '0;
                        press_evt_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HELD: begin
                    // Release is debounced but deliberately produces no event.
                    if (!s) begin
                        state_q <= RELEASE_CHK;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                RELEASE_CHK: begin
                    if (s) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(DB_CYCLES)) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= RELEASED;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/jk_cmd_ctrl.sv
// Button front-end for the negedge JK flip-flop: three debounced buttons, priority
// CLR > SET > TOG, registered single-cycle j/k pulses and an issued-command counter.
module jk_cmd_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_set,
    input  logic       btn_clr,
    input  logic       btn_tog,
    output logic       j,
    output logic       k,
    output logic       cmd_valid,
    output logic [7:0] cmd_cnt
);

    logic       evt_set, evt_clr, evt_tog;
    jk_cmd_t    cmd_d;
    logic [1:0] jk_d;
    logic       j_q, k_q, cmd_valid_q;
    logic [7:0] cmd_cnt_q;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
        .clk(clk), .reset(reset), .btn_raw(btn_set), .press_evt(evt_set)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk(clk), .reset(reset), .btn_raw(btn_clr), .press_evt(evt_clr)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_tog (
        .clk(clk), .reset(reset), .btn_raw(btn_tog), .press_evt(evt_tog)
    );

    // Losing simultaneous events are dropped, not queued.
    always_comb begin
        cmd_d = CMD_NONE;
        if (evt_clr)      cmd_d = CMD_CLR;
        else if (evt_set) cmd_d = CMD_SET;
        else if (evt_tog) cmd_d = CMD_TOG;
        jk_d = to_jk(cmd_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            j_q         <= 1'b0;
            k_q         <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_cnt_q   <= '0;
        end else begin
            j_q         <= jk_d[1];
            k_q         <= jk_d[0];
            cmd_valid_q <= (cmd_d != CMD_NONE);
            if (cmd_d != CMD_NONE) cmd_cnt_q <= cmd_cnt_q + 8'd1;
        end
    end

    assign j         = j_q;
    assign k         = k_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_cnt   = cmd_cnt_q;

endmodule

// File: tb/tb_jk_cmd_ctrl.sv
// Bench for jk_cmd_ctrl: directed button scenarios plus random bouncing, checked every
// cycle against a run-length debounce model.
module tb_jk_cmd_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_set = 1'b0, btn_clr = 1'b0, btn_tog = 1'b0;
    logic       j, k, cmd_valid;
    logic [7:0] cmd_cnt;

    int vectors = 0;
    int miscompares = 0;

    jk_cmd_ctrl #(.DB_CYCLES(DB)) dut (
        .clk(clk), .reset(reset),
        .btn_set(btn_set), .btn_clr(btn_clr), .btn_tog(btn_tog),
        .j(j), .k(k), .cmd_valid(cmd_valid), .cmd_cnt(cmd_cnt)
    );

    always #5 clk = ~clk;

    // Model: a button's debounced level flips once DB+1 consecutive synchronised
    // samples disagree with it; a 0->1 flip is a press event. Index 0=set,1=clr,2=tog.
    bit         p1[3], p2[3], deb[3], evt[3];
    int         run[3];
    bit         exp_j, exp_k, exp_v;
    logic [7:0] exp_cnt;

    int         edge_idx;
    int         pulses;
    int         last_pulse_edge;
    logic [1:0] last_jk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_edge();
        bit raw[3];
        bit s;
        raw[0] = btn_set; raw[1] = btn_clr; raw[2] = btn_tog;
        if (!reset) begin
            for (int b = 0; b < 3; b++) begin
                p1[b] = 0; p2[b] = 0; deb[b] = 0; evt[b] = 0; run[b] = 0;
            end
            exp_j = 0; exp_k = 0; exp_v = 0; exp_cnt = 8'd0;
        end else begin
            exp_v = evt[0] | evt[1] | evt[2];
            if (evt[1])      begin exp_j = 0; exp_k = 1; end
            else if (evt[0]) begin exp_j = 1; exp_k = 0; end
            else if (evt[2]) begin exp_j = 1; exp_k = 1; end
            else             begin exp_j = 0; exp_k = 0; end
            if (exp_v) exp_cnt = exp_cnt + 8'd1;
            for (int b = 0; b < 3; b++) begin
                s = p2[b];
                p2[b] = p1[b];
                p1[b] = raw[b];
                evt[b] = 0;
                if (s != deb[b]) run[b]++;
                else run[b] = 0;
                if (run[b] == DB + 1) begin
                    deb[b] = s;
                    run[b] = 0;
                    evt[b] = s;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_idx++;
        model_edge();
        @(negedge clk);
        check("j", {7'd0, j}, {7'd0, exp_j});
        check("k", {7'd0, k}, {7'd0, exp_k});
        check("cmd_valid", {7'd0, cmd_valid}, {7'd0, exp_v});
        check("cmd_cnt", cmd_cnt, exp_cnt);
        if (cmd_valid === 1'b1) begin
            pulses++;
            last_pulse_edge = edge_idx;
            last_jk = {j, k};
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        btn_set = 0; btn_clr = 0; btn_tog = 0;
        reset = 0;
        steps(3);
        reset = 1;
        steps(1);
        pulses = 0;
        last_pulse_edge = -1;
        last_jk = 2'b00;
    endtask

    initial begin
        edge_idx = 0;
        @(negedge clk);
        do_reset();
        check("reset_cnt", cmd_cnt, 8'd0);

        // 1: clean set press, held long: one pulse after posedge DB+3.
        btn_set = 1; edge_idx = -1;
        steps(60);
        check("t1_pulses", 8'(pulses), 8'd1);
        check("t1_edge", 8'(last_pulse_edge), 8'(DB + 3));
        check("t1_jk", {6'd0, last_jk}, 8'b10);
        check("t1_cnt", cmd_cnt, 8'd1);

        // 2: toggle bounces 1,0,1,0 then steady high.
        do_reset();
        btn_tog = 1; edge_idx = -1;
        step(); btn_tog = 0;
        step(); btn_tog = 1;
        step(); btn_tog = 0;
        step(); btn_tog = 1;
        steps(20);
        check("t2_pulses", 8'(pulses), 8'd1);
        check("t2_edge", 8'(last_pulse_edge), 8'(4 + DB + 3));
        check("t2_jk", {6'd0, last_jk}, 8'b11);

        // 3: clear and set together: clear wins, single command.
        do_reset();
        btn_clr = 1; btn_set = 1;
        steps(20);
        check("t3_pulses", 8'(pulses), 8'd1);
        check("t3_jk", {6'd0, last_jk}, 8'b01);
        check("t3_cnt", cmd_cnt, 8'd1);

        // 4: 256 toggle presses wrap the counter to 0.
        do_reset();
        for (int n = 0; n < 256; n++) begin
            btn_tog = 1; steps(8);
            btn_tog = 0; steps(8);
        end
        check("t4_pulses", 8'(pulses >> 1), 8'd128);
        check("t4_cnt", cmd_cnt, 8'd0);

        // 5: reset mid-debounce; button held through reset release.
        do_reset();
        btn_set = 1; edge_idx = -1;
        steps(4);
        reset = 0;
        #1;
        check("t5_rst_j", {7'd0, j}, 8'd0);
        check("t5_rst_v", {7'd0, cmd_valid}, 8'd0);
        steps(2);
        reset = 1;
        steps(20);
        check("t5_pulses", 8'(pulses), 8'd1);
        check("t5_edge", 8'(last_pulse_edge), 8'(6 + DB + 3));

        // 6: short release glitch while held, then a true release and re-press.
        do_reset();
        btn_set = 1; steps(12);
        pulses = 0;
        btn_set = 0; steps(2);
        btn_set = 1; steps(20);
        check("t6_glitch", 8'(pulses), 8'd0);
        btn_set = 0; steps(8);
        btn_set = 1; steps(12);
        check("t6_repress", 8'(pulses), 8'd1);

        // Random bouncing on all buttons with occasional resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(5) == 0) btn_set = ~btn_set;
            if ($urandom_range(5) == 0) btn_clr = ~btn_clr;
            if ($urandom_range(5) == 0) btn_tog = ~btn_tog;
            if (!reset) reset = 1;
            else if ($urandom_range(499) == 0) reset = 0;
            step();
        end
        reset = 1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
